// File: rtl/dual_bank_arbiter_if.sv
// Request/response bundle for the two ports of dual_bank_arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants and read data.
interface dual_bank_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              a_valid;
    logic              a_ready;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_valid;
    logic              b_ready;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic [7:0]        conflict_cnt;

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  a_ready, a_rvalid, a_rdata,
        input  b_ready, b_rvalid, b_rdata,
        input  conflict_cnt
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output a_ready, a_rvalid, a_rdata,
        output b_ready, b_rvalid, b_rdata,
        output conflict_cnt
    );
endinterface

// File: rtl/dual_bank_arbiter.sv
// Two-port access to NUM_BANKS word-interleaved banks; same-bank collisions are
// resolved by a toggling priority token, and the losing port simply stalls.
module dual_bank_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 6,
    parameter int NUM_BANKS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dual_bank_arbiter_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int DEPTH  = 1 << ROW_W;

    logic [BANK_W-1:0] a_bank, b_bank;
    logic [ROW_W-1:0]  a_row, b_row;
    logic              conflict, a_ready, b_ready;
    logic              a_fire, b_fire, a_wr, b_wr;

    logic              tok_q, tok_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic [DATA_W-1:0] a_bank_rd [NUM_BANKS];
    logic [DATA_W-1:0] b_bank_rd [NUM_BANKS];

    assign a_bank = bus.a_addr[BANK_W-1:0];
    assign b_bank = bus.b_addr[BANK_W-1:0];
    assign a_row  = bus.a_addr[ADDR_W-1:BANK_W];
    assign b_row  = bus.b_addr[ADDR_W-1:BANK_W];

    // Only a genuine same-bank collision ever withholds ready.
    assign conflict = bus.a_valid & bus.b_valid & (a_bank == b_bank);
    assign a_ready  = ~conflict | ~tok_q;
    assign b_ready  = ~conflict |  tok_q;
    assign a_fire   = bus.a_valid & a_ready;
    assign b_fire   = bus.b_valid & b_ready;
    assign a_wr     = a_fire & bus.a_we & rst_n;
    assign b_wr     = b_fire & bus.b_we & rst_n;

    // Storage has no reset; a bank is written by at most one port per edge
    // because two ports in the same bank always collide.
    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic              wr_a, wr_b;

        assign wr_a = a_wr & (a_bank == BANK_W'(g));
        assign wr_b = b_wr & (b_bank == BANK_W'(g));

        always_ff @(posedge clk) begin
            if (wr_a)      mem_q[a_row] <= bus.a_wdata;
            else if (wr_b) mem_q[b_row] <= bus.b_wdata;
        end

        assign a_bank_rd[g] = mem_q[a_row];
        assign b_bank_rd[g] = mem_q[b_row];
    end

    always_comb begin
        tok_d      = tok_q ^ conflict;
        cnt_d      = cnt_q;
        if (conflict && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        a_rvalid_d = a_fire & ~bus.a_we;
        b_rvalid_d = b_fire & ~bus.b_we;
        a_rdata_d  = a_rvalid_d ? a_bank_rd[a_bank] : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? b_bank_rd[b_bank] : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_q      <= 1'b0;
            cnt_q      <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            tok_q      <= tok_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign bus.a_ready      = a_ready;
    assign bus.b_ready      = b_ready;
    assign bus.a_rvalid     = a_rvalid_q;
    assign bus.b_rvalid     = b_rvalid_q;
    assign bus.a_rdata      = a_rdata_q;
    assign bus.b_rdata      = b_rdata_q;
    assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_dual_bank_arbiter.sv
// Directed and random checks of dual_bank_arbiter against a word-level memory
// model with a priority bit and a saturating conflict count.
module tb_dual_bank_arbiter;
    localparam int DW = 8;
    localparam int AW = 6;
    localparam int NB = 4;
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dual_bank_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    dual_bank_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem_m [WORDS];
    bit            known [WORDS];
    bit            tok;
    int            cnt;
    bit            e_arv, e_brv, e_ark, e_brk;
    logic [DW-1:0] e_ard, e_brd;
    bit            a_fired, b_fired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input bit v, input bit we, input int addr, input int data);
        bus.a_valid = v; bus.a_we = we; bus.a_addr = AW'(addr); bus.a_wdata = DW'(data);
    endtask

    task automatic set_b(input bit v, input bit we, input int addr, input int data);
        bus.b_valid = v; bus.b_we = we; bus.b_addr = AW'(addr); bus.b_wdata = DW'(data);
    endtask

    task automatic model_reset();
        tok = 0; cnt = 0;
        e_arv = 0; e_brv = 0;
        e_ard = '0; e_brd = '0;
        e_ark = 1; e_brk = 1;
    endtask

    task automatic check_outs();
        chk("a_rvalid", bus.a_rvalid, e_arv);
        chk("b_rvalid", bus.b_rvalid, e_brv);
        chk("conflict_cnt", bus.conflict_cnt, cnt);
        if (e_ark) chk("a_rdata", bus.a_rdata, e_ard);
        if (e_brk) chk("b_rdata", bus.b_rdata, e_brd);
    endtask

    // One clock: check grants for the current request, advance the model, check outputs.
    task automatic step();
        bit conf, ar, br;
        int aa, ba;
        #1;
        aa = int'(bus.a_addr);
        ba = int'(bus.b_addr);
        conf = bus.a_valid && bus.b_valid && ((aa % NB) == (ba % NB));
        ar = !conf || !tok;
        br = !conf || tok;
        chk("a_ready", bus.a_ready, ar);
        chk("b_ready", bus.b_ready, br);
        a_fired = bus.a_valid && ar;
        b_fired = bus.b_valid && br;
        @(posedge clk);
        e_arv = a_fired && !bus.a_we;
        e_brv = b_fired && !bus.b_we;
        if (e_arv) begin e_ard = mem_m[aa]; e_ark = known[aa]; end
        if (e_brv) begin e_brd = mem_m[ba]; e_brk = known[ba]; end
        if (a_fired && bus.a_we) begin mem_m[aa] = bus.a_wdata; known[aa] = 1; end
        if (b_fired && bus.b_we) begin mem_m[ba] = bus.b_wdata; known[ba] = 1; end
        if (conf) begin
            tok = !tok;
            if (cnt < 255) cnt++;
        end
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int a_grants, b_grants;
        for (int i = 0; i < WORDS; i++) known[i] = 0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        @(posedge clk);
        #1;
        do_reset();

        // A write then A read of the same word
        set_a(1, 1, 'h04, 'h5A); step();
        set_a(1, 0, 'h04, 0);    step();
        set_a(0, 0, 0, 0);       step();
        chk("rd_after_wr", bus.a_rdata, 8'h5A);

        // parallel writes to different banks, then parallel reads
        set_a(1, 1, 'h01, 'h11); set_b(1, 1, 'h02, 'h22); step();
        set_a(1, 0, 'h01, 0);    set_b(1, 0, 'h02, 0);    step();
        set_a(0, 0, 0, 0);       set_b(0, 0, 0, 0);       step();
        chk("par_a_rdata", bus.a_rdata, 8'h11);
        chk("par_cnt", bus.conflict_cnt, 0);

        // two-cycle bank-0 read collision right after reset
        do_reset();
        set_a(1, 0, 'h00, 0); set_b(1, 0, 'h04, 0);
        step();
        step();
        chk("coll_cnt", bus.conflict_cnt, 2);
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        step();

        // same-address write/read: A wins, B then reads the new value
        do_reset();
        set_a(1, 1, 'h08, 'h7E); set_b(1, 0, 'h08, 0);
        step();
        if (a_fired) set_a(0, 0, 0, 0);
        step();
        set_b(0, 0, 0, 0);
        step();
        chk("same_addr_b_rdata", bus.b_rdata, 8'h7E);

        // fill every word, A on even and B on odd addresses
        for (int i = 0; i < WORDS / 2; i++) begin
            set_a(1, 1, 2 * i, $urandom);
            set_b(1, 1, 2 * i + 1, $urandom);
            step();
        end

        // random traffic; a stalled requester keeps its request unchanged
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        a_fired = 1; b_fired = 1;
        for (int n = 0; n < 400; n++) begin
            if (!(bus.a_valid && !a_fired))
                set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, WORDS - 1), $urandom);
            if (!(bus.b_valid && !b_fired))
                set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, WORDS - 1), $urandom);
            step();
        end

        // sustained conflicts: counter saturates, grants alternate
        do_reset();
        a_grants = 0; b_grants = 0;
        set_a(1, 0, 'h05, 0); set_b(1, 0, 'h09, 0);
        for (int n = 0; n < 300; n++) begin
            step();
            if (n == 0) chk("first_grant_a", a_fired, 1);
            a_grants += int'(a_fired);
            b_grants += int'(b_fired);
        end
        chk("sat_cnt", bus.conflict_cnt, 255);
        chk("a_grants", a_grants, 150);
        chk("b_grants", b_grants, 150);

        // reset mid-operation clears pending rvalid without a clock edge
        do_reset();
        set_a(1, 0, 'h01, 0); set_b(1, 0, 'h05, 0);
        step();
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_a_rvalid", bus.a_rvalid, 0);
        chk("rst_cnt", bus.conflict_cnt, 0);
        chk("rst_a_rdata", bus.a_rdata, 0);
        model_reset();

        // writes attempted while in reset must not land
        set_a(1, 1, 'h30, int'(~mem_m['h30]));
        @(posedge clk);
        #1;
        set_a(0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        set_a(1, 0, 'h30, 0);
        step();
        chk("rst_no_write", bus.a_rdata, mem_m['h30]);
        set_a(1, 0, 'h02, 0); set_b(1, 0, 'h06, 0);
        step();
        chk("post_rst_grant_a", a_fired, 1);
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
